// File: rtl/fu_issue_ctrl.sv
// fu_issue_ctrl: issue/return controller for the functional unit.
// Captures FU_* on accept and holds them for the unit latency, then registers the result.
// Backpressure: at most one op is in flight. A response is held until RSP_READY.
module fu_issue_ctrl #(
  parameter int WIDTH     = 32,
  parameter int ALUBS_LAT = 1,
  parameter int MADD_LAT  = 2,
  parameter int CNT_W     = 4
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [4:0]       REQ_INST,
  input  logic [WIDTH-1:0] REQ_A,
  input  logic [WIDTH-1:0] REQ_B,
  input  logic [WIDTH-1:0] REQ_C,
  output logic [4:0]       FU_INST,
  output logic [WIDTH-1:0] FU_A,
  output logic [WIDTH-1:0] FU_B,
  output logic [WIDTH-1:0] FU_C,
  input  logic [WIDTH-1:0] FU_Z,
  input  logic [3:0]       FU_FLAGS,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [WIDTH-1:0] RSP_Z,
  output logic [3:0]       RSP_FLAGS,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   lat_d;
  logic [4:0]         fu_inst_q;
  logic [WIDTH-1:0]   fu_a_q, fu_b_q, fu_c_q;
  logic               rsp_vld_q;
  logic [WIDTH-1:0]   rsp_z_q;
  logic [3:0]         rsp_flags_q;
  logic               accept;
  logic               is_alu_q;

  // Request acceptance: free in IDLE, or in DONE when the response leaves this cycle.
  always_comb begin
    REQ_READY = 1'b0;
    if (!RESET) begin
      REQ_READY = (state_q == IDLE) || ((state_q == DONE) && RSP_READY);
    end
    accept = REQ_VALID && REQ_READY;
    // INST[3]=1 with INST[4]=1 is MADD; everything else uses the ALU/shifter latency.
    lat_d = (REQ_INST[3] && REQ_INST[4]) ? CNT_W'(MADD_LAT) : CNT_W'(ALUBS_LAT);
    // Flags are only meaningful for ALU ops (INST[3]=1, INST[4]=0).
    is_alu_q = fu_inst_q[3] && !fu_inst_q[4];
  end

  // Issue/return FSM with all functional-unit and response outputs registered.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fu_inst_q   <= '0;
      fu_a_q      <= '0;
      fu_b_q      <= '0;
      fu_c_q      <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_z_q     <= '0;
      rsp_flags_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            fu_inst_q <= REQ_INST;
            fu_a_q    <= REQ_A;
            fu_b_q    <= REQ_B;
            fu_c_q    <= REQ_C;
            cnt_q     <= lat_d;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          // Operands stay frozen: the unit latches its clock enables mid-cycle.
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            rsp_z_q     <= FU_Z;
            rsp_flags_q <= is_alu_q ? FU_FLAGS : 4'b0000;
            rsp_vld_q   <= 1'b1;
            fu_inst_q   <= '0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (RSP_READY) begin
            rsp_vld_q <= 1'b0;
            if (accept) begin
              fu_inst_q <= REQ_INST;
              fu_a_q    <= REQ_A;
              fu_b_q    <= REQ_B;
              fu_c_q    <= REQ_C;
              cnt_q     <= lat_d;
              state_q   <= EXEC;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Output wiring from the registered state.
  always_comb begin
    FU_INST   = fu_inst_q;
    FU_A      = fu_a_q;
    FU_B      = fu_b_q;
    FU_C      = fu_c_q;
    RSP_VALID = rsp_vld_q;
    RSP_Z     = rsp_z_q;
    RSP_FLAGS = rsp_flags_q;
    BUSY      = (state_q == EXEC) || (state_q == DONE);
  end

endmodule

// File: tb/tb_fu_issue_ctrl.sv
// tb_fu_issue_ctrl: directed bench for fu_issue_ctrl with a behavioural functional unit.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expected values are hand-computed constants.
module tb_fu_issue_ctrl;

  logic        CLOCK;
  logic        RESET;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [4:0]  REQ_INST;
  logic [31:0] REQ_A, REQ_B, REQ_C;
  logic [4:0]  FU_INST;
  logic [31:0] FU_A, FU_B, FU_C;
  logic [31:0] FU_Z;
  logic [3:0]  FU_FLAGS;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_Z;
  logic [3:0]  RSP_FLAGS;
  logic        BUSY;

  int total = 0;
  int bad   = 0;

  fu_issue_ctrl #(.WIDTH(32), .ALUBS_LAT(1), .MADD_LAT(2), .CNT_W(4)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_INST(REQ_INST),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_C(REQ_C),
    .FU_INST(FU_INST), .FU_A(FU_A), .FU_B(FU_B), .FU_C(FU_C),
    .FU_Z(FU_Z), .FU_FLAGS(FU_FLAGS),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_Z(RSP_Z), .RSP_FLAGS(RSP_FLAGS), .BUSY(BUSY)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Behavioural functional unit: shifter, MADD or ALU add, selected like the unit's output mux.
  logic [3:0] flags_v;
  always_comb begin
    if (!FU_INST[3])     FU_Z = FU_A << FU_B[4:0];
    else if (FU_INST[4]) FU_Z = FU_A * FU_B + FU_C;
    else                 FU_Z = FU_A + FU_B;
    FU_FLAGS = flags_v;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic drive(input logic [4:0] inst, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c);
    REQ_VALID = 1'b1;
    REQ_INST  = inst;
    REQ_A     = a;
    REQ_B     = b;
    REQ_C     = c;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; REQ_VALID = 1'b0; REQ_INST = '0; REQ_A = '0; REQ_B = '0; REQ_C = '0;
    RSP_READY = 1'b0; flags_v = 4'b0000;
    #3;
    check("rst_fu_inst", 32'(FU_INST), 0);
    check("rst_rsp_valid", 32'(RSP_VALID), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_rsp_z", RSP_Z, 0);
    step(); step();
    @(negedge CLOCK);
    RESET = 1'b0;
    #1;
    check("post_rst_req_ready", 32'(REQ_READY), 1);
    @(posedge CLOCK); #1;

    // ALU op, latency 1
    drive(5'b01010, 32'd5, 32'd3, 32'd0); flags_v = 4'b0010;
    step();
    check("alu_fu_inst", 32'(FU_INST), 32'b01010);
    check("alu_busy", 32'(BUSY), 1);
    check("alu_req_ready_exec", 32'(REQ_READY), 0);
    check("alu_rsp_not_yet", 32'(RSP_VALID), 0);
    REQ_VALID = 1'b0;
    step();
    check("alu_rsp_valid", 32'(RSP_VALID), 1);
    check("alu_rsp_z", RSP_Z, 32'd8);
    check("alu_rsp_flags", 32'(RSP_FLAGS), 32'b0010);
    check("alu_fu_inst_clr", 32'(FU_INST), 0);
    RSP_READY = 1'b1; #1;
    check("done_req_ready_comb", 32'(REQ_READY), 1);
    step();
    check("alu_consumed", 32'(RSP_VALID), 0);
    check("alu_idle_busy", 32'(BUSY), 0);
    RSP_READY = 1'b0;

    // MADD op, latency 2; flags from the unit must be discarded
    drive(5'b11100, 32'd3, 32'd4, 32'd5); flags_v = 4'b1111;
    step();
    check("madd_fu_inst_c1", 32'(FU_INST), 32'b11100);
    REQ_VALID = 1'b0; REQ_A = 32'hdead; REQ_C = 32'hbeef;
    step();
    check("madd_fu_inst_c2", 32'(FU_INST), 32'b11100);
    check("madd_fu_a_held", FU_A, 32'd3);
    check("madd_fu_c_held", FU_C, 32'd5);
    check("madd_rsp_not_yet", 32'(RSP_VALID), 0);
    step();
    check("madd_rsp_valid", 32'(RSP_VALID), 1);
    check("madd_rsp_z", RSP_Z, 32'd17);
    check("madd_rsp_flags", 32'(RSP_FLAGS), 0);
    RSP_READY = 1'b1;
    step();
    check("madd_consumed", 32'(RSP_VALID), 0);
    RSP_READY = 1'b0;

    // Shifter op with 3 cycles of response backpressure and a pending request
    drive(5'b00000, 32'h1, 32'd4, 32'd0); flags_v = 4'b1010;
    step();
    REQ_VALID = 1'b0;
    step();
    check("shf_rsp_flags", 32'(RSP_FLAGS), 0);
    drive(5'b01010, 32'd7, 32'd7, 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      #1;
      check("bp_rsp_valid", 32'(RSP_VALID), 1);
      check("bp_rsp_z", RSP_Z, 32'h10);
      check("bp_busy", 32'(BUSY), 1);
      check("bp_req_ready", 32'(REQ_READY), 0);
      check("bp_fu_inst", 32'(FU_INST), 0);
    end
    REQ_VALID = 1'b0; RSP_READY = 1'b1;
    step();
    check("bp_consumed", 32'(RSP_VALID), 0);
    check("bp_idle_busy", 32'(BUSY), 0);
    RSP_READY = 1'b0;

    // Back-to-back: consume and issue at the same edge
    drive(5'b01010, 32'd2, 32'd3, 32'd0); flags_v = 4'b0001;
    step();
    REQ_VALID = 1'b0;
    step();
    check("b2b_first_z", RSP_Z, 32'd5);
    drive(5'b01010, 32'd4, 32'd5, 32'd0); RSP_READY = 1'b1;
    #1;
    check("b2b_req_ready", 32'(REQ_READY), 1);
    step();
    check("b2b_rsp_dropped", 32'(RSP_VALID), 0);
    check("b2b_fu_inst", 32'(FU_INST), 32'b01010);
    check("b2b_fu_a", FU_A, 32'd4);
    check("b2b_busy", 32'(BUSY), 1);
    REQ_VALID = 1'b0; RSP_READY = 1'b0;
    step();
    check("b2b_rsp_valid", 32'(RSP_VALID), 1);
    check("b2b_rsp_z", RSP_Z, 32'd9);
    // response left pending: reset must clear it

    // Reset mid-MADD: response held, then issue... first consume, then MADD and reset
    RSP_READY = 1'b1;
    drive(5'b11100, 32'd6, 32'd6, 32'd1);
    step();
    check("rmadd_accepted", 32'(FU_INST), 32'b11100);
    REQ_VALID = 1'b0; RSP_READY = 1'b0;
    step();
    #2;
    RESET = 1'b1;
    #1;
    check("rmid_fu_inst", 32'(FU_INST), 0);
    check("rmid_fu_a", FU_A, 0);
    check("rmid_fu_b", FU_B, 0);
    check("rmid_fu_c", FU_C, 0);
    check("rmid_rsp_valid", 32'(RSP_VALID), 0);
    check("rmid_rsp_z", RSP_Z, 0);
    check("rmid_rsp_flags", 32'(RSP_FLAGS), 0);
    check("rmid_busy", 32'(BUSY), 0);
    step();
    @(negedge CLOCK);
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rmid_no_rsp", 32'(RSP_VALID), 0);
    end
    drive(5'b01010, 32'd1, 32'd1, 32'd0); flags_v = 4'b0100;
    #1;
    check("after_rst_req_ready", 32'(REQ_READY), 1);
    step();
    check("after_rst_fu_inst", 32'(FU_INST), 32'b01010);
    REQ_VALID = 1'b0;
    step();
    check("after_rst_rsp_z", RSP_Z, 32'd2);
    check("after_rst_flags", 32'(RSP_FLAGS), 32'b0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
